alu_sequencer: RTL and testbench
================================

# alu_sequencer

Parametrised hard-wired control sequencer for the register-file datapath. Runs the fetch/execute T-state sequence for three-register ALU instructions (T0 fetch through T5/T6 write-back) and drives every datapath strobe directly. It adds memory wait states, run/stall control, illegal-opcode trapping, HI/LO write-back for MUL/DIV and a retired-instruction counter. Sits beside `Datapath` and replaces hand-sequenced control.

## Interface
- DATA_W, 32, instruction/IR width
- NUM_REGS, 16, general registers; RSEL_W = clog2(NUM_REGS)
- OPC_W, 5, opcode field width
- ALU_OP_W, 4, ALU operation code width
- CNT_W, 16, retired-instruction counter width
- Clock  in  1  single clock, rising edge
- clear  in  1  asynchronous, active-low reset
- run  in  1  1 = advance; 0 = stall
- mem_ready  in  1  memory read data valid on Mdatain this cycle
- ir  in  DATA_W  current IR contents from datapath
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive enables
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load enables
- IncPC, Read  out  1 each  PC increment, memory read
- Rout  out  NUM_REGS  one-hot register bus drive
- Rin  out  NUM_REGS  one-hot register load
- alu_op  out  ALU_OP_W  ALU operation, valid in T4 only, else ALU_NOP
- illegal  out  1  one-cycle pulse on undefined opcode
- instr_count  out  CNT_W  retired instructions
- state  out  4  current state (debug)

## Operation
- Fields: opcode = ir[DATA_W-1 -: OPC_W]; Ra, Rb, Rc are consecutive RSEL_W fields below it.
- States: IDLE, T0–T6. Outputs are Moore, decoded from state and ir. All outputs are 0 in IDLE and whenever run=0.
- IDLE → T0 when run=1.
- T0: PCout, MARin, IncPC, Zin. → T1.
- T1: Zlowout, PCin, Read, MDRin. Holds in T1 while mem_ready=0; PCin asserts only in the cycle mem_ready=1. → T2 on mem_ready.
- T2: MDRout, IRin. → T3.
- T3: ir decoded (IR loaded at the end of T2).
  - Illegal opcode: illegal=1, no other strobe, → T0, not counted.
  - NOP: no strobe, → T0, counted.
  - Otherwise: Rout[Rb], Yin. → T4.
- T4: Rout[Rc], alu_op per opcode, Zin. → T5.
- T5: Zlowout, plus Rin[Ra] (single result) or LOin (MUL/DIV). MUL/DIV → T6; others → T0, counted.
- T6: Zhighout, HIin. → T0, counted.
- run=0 in any state: state frozen, all strobes 0. Resumes in the same state.
- instr_count increments by 1 on each retirement and wraps 2^CNT_W−1 → 0.
- Rout/Rin are strictly one-hot or zero. Never more than one bus driver is active.

## Timing
- Reset: state=IDLE, all outputs 0, instr_count=0, illegal=0.
- clear asserted mid-instruction: immediate return to IDLE. No strobe survives. Counter cleared.
- Latency with mem_ready=1 in the first T1 cycle:
  - ALU op: 6 cycles, T0–T5.
  - MUL/DIV: 7 cycles.
  - NOP/illegal: 4 cycles.
- Each mem_ready=0 cycle in T1 adds 1 cycle.
- instr_count updates on the clock edge leaving the retiring state.
- illegal is high exactly during the T3 cycle.

## Structure
- Package alu_seq_pkg holds:
  - Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000, NOP 11010.
  - ALU_OP encodings including ALU_NOP.
  - State encoding.
- Sub-module opcode_decoder (combinational): opcode → {alu_op, legal, is_wide, is_nop}.
- Top level holds the FSM, the counter and the one-hot register decode.

## Test plan
- AND, ir=0x28918000, mem_ready=1 → T3 Rout=0x0004, Yin; T4 Rout=0x0008, alu_op=AND, Zin; T5 Rin=0x0002, Zlowout; instr_count=1 after 6 cycles.
- Same instruction with mem_ready low for 3 T1 cycles → T1 lasts 4 cycles, PCin only in the last; retirement at cycle 9.
- MUL R1,R2,R3 (opcode 01111) → T5 LOin, Rin=0; T6 Zhighout, HIin; 7 cycles.
- Opcode 11111 → illegal pulse in T3, no Rin/Yin; back to T0; instr_count unchanged.
- run dropped for 5 cycles in T4 → all strobes 0, state=T4 held; resume completes write-back to Ra. clear pulsed in T4 → IDLE, outputs 0, count 0.
- CNT_W=4, 16 back-to-back NOPs → instr_count 15 → 0.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer shared types: opcodes, ALU op codes, FSM states.
// Imported by the decoder and the sequencer top.
package alu_seq_pkg;

   typedef logic [4:0] opcode_t;

   localparam opcode_t OP_ADD = 5'b00011;
   localparam opcode_t OP_SUB = 5'b00100;
   localparam opcode_t OP_AND = 5'b00101;
   localparam opcode_t OP_OR  = 5'b00110;
   localparam opcode_t OP_SHR = 5'b00111;
   localparam opcode_t OP_SHL = 5'b01001;
   localparam opcode_t OP_ROR = 5'b01010;
   localparam opcode_t OP_ROL = 5'b01011;
   localparam opcode_t OP_MUL = 5'b01111;
   localparam opcode_t OP_DIV = 5'b10000;
   localparam opcode_t OP_NOP = 5'b11010;

   typedef enum logic [3:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_SUB = 4'd2,
      ALU_AND = 4'd3,
      ALU_OR  = 4'd4,
      ALU_SHR = 4'd5,
      ALU_SHL = 4'd6,
      ALU_ROR = 4'd7,
      ALU_ROL = 4'd8,
      ALU_MUL = 4'd9,
      ALU_DIV = 4'd10
   } alu_op_e;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      T0   = 4'd1,
      T1   = 4'd2,
      T2   = 4'd3,
      T3   = 4'd4,
      T4   = 4'd5,
      T5   = 4'd6,
      T6   = 4'd7
   } state_e;

   typedef struct packed {
      alu_op_e op;
      logic    legal;
      logic    wide;
      logic    nop;
   } dec_t;

endpackage

// File: rtl/alu_sequencer_decoder.sv
// opcode_decoder: combinational opcode classification for the
// sequencer (ALU op, legality, HI/LO write-back, NOP).
module opcode_decoder
   import alu_seq_pkg::*;
#(
   parameter int OPC_W = 5
) (
   input  logic [OPC_W-1:0] opcode,
   output dec_t             dec
);

   always_comb begin
      dec.op    = ALU_NOP;
      dec.legal = 1'b1;
      dec.wide  = 1'b0;
      dec.nop   = 1'b0;
      unique case (1'b1)
         (opcode == OPC_W'(OP_ADD)): dec.op = ALU_ADD;
         (opcode == OPC_W'(OP_SUB)): dec.op = ALU_SUB;
         (opcode == OPC_W'(OP_AND)): dec.op = ALU_AND;
         (opcode == OPC_W'(OP_OR)):  dec.op = ALU_OR;
         (opcode == OPC_W'(OP_SHR)): dec.op = ALU_SHR;
         (opcode == OPC_W'(OP_SHL)): dec.op = ALU_SHL;
         (opcode == OPC_W'(OP_ROR)): dec.op = ALU_ROR;
         (opcode == OPC_W'(OP_ROL)): dec.op = ALU_ROL;
         (opcode == OPC_W'(OP_MUL)): begin
            dec.op   = ALU_MUL;
            dec.wide = 1'b1;
         end
         (opcode == OPC_W'(OP_DIV)): begin
            dec.op   = ALU_DIV;
            dec.wide = 1'b1;
         end
         (opcode == OPC_W'(OP_NOP)): dec.nop = 1'b1;
         default: dec.legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: hard-wired T-state control for the register-file
// datapath, with wait states, stall, trap and retire counter.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int OPC_W    = 5,
   parameter int ALU_OP_W = 4,
   parameter int CNT_W    = 16
) (
   input  logic                Clock,
   input  logic                clear,
   input  logic                run,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   ir,
   output logic                PCout,
   output logic                Zlowout,
   output logic                Zhighout,
   output logic                MDRout,
   output logic                MARin,
   output logic                PCin,
   output logic                MDRin,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                HIin,
   output logic                LOin,
   output logic                IncPC,
   output logic                Read,
   output logic [NUM_REGS-1:0] Rout,
   output logic [NUM_REGS-1:0] Rin,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal,
   output logic [CNT_W-1:0]    instr_count,
   output logic [3:0]          state
);

   localparam int RSEL_W = $clog2(NUM_REGS);
   localparam int RA_HI  = DATA_W - OPC_W - 1;
   localparam int RB_HI  = RA_HI - RSEL_W;
   localparam int RC_HI  = RB_HI - RSEL_W;

   logic [OPC_W-1:0]  opcode;
   logic [RSEL_W-1:0] ra, rb, rc;
   logic              unused_ir;
   dec_t              dec;
   state_e            state_q, state_d;
   logic              retire;

   assign opcode    = ir[DATA_W-1 -: OPC_W];
   assign ra        = ir[RA_HI -: RSEL_W];
   assign rb        = ir[RB_HI -: RSEL_W];
   assign rc        = ir[RC_HI -: RSEL_W];
   assign unused_ir = ^ir[RC_HI-RSEL_W:0];
   assign state     = state_q;

   opcode_decoder #(.OPC_W(OPC_W)) u_dec (
      .opcode (opcode),
      .dec    (dec)
   );

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q     <= IDLE;
         instr_count <= '0;
      end else begin
         state_q <= state_d;
         if (retire) instr_count <= instr_count + CNT_W'(1);
      end
   end

   // Every strobe is gated by run so a stall freezes the datapath too.
   always_comb begin
      state_d  = state_q;
      retire   = 1'b0;
      PCout    = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      MDRout   = 1'b0;
      MARin    = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zin      = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      Rout     = '0;
      Rin      = '0;
      alu_op   = ALU_OP_W'(ALU_NOP);
      illegal  = 1'b0;
      if (run) begin
         unique case (state_q)
            IDLE: state_d = T0;
            T0: begin
               PCout   = 1'b1;
               MARin   = 1'b1;
               IncPC   = 1'b1;
               Zin     = 1'b1;
               state_d = T1;
            end
            T1: begin
               Zlowout = 1'b1;
               Read    = 1'b1;
               MDRin   = 1'b1;
               if (mem_ready) begin
                  PCin    = 1'b1;
                  state_d = T2;
               end
            end
            T2: begin
               MDRout  = 1'b1;
               IRin    = 1'b1;
               state_d = T3;
            end
            T3: begin
               if (!dec.legal) begin
                  illegal = 1'b1;
                  state_d = T0;
               end else if (dec.nop) begin
                  retire  = 1'b1;
                  state_d = T0;
               end else begin
                  Rout    = NUM_REGS'(1) << rb;
                  Yin     = 1'b1;
                  state_d = T4;
               end
            end
            T4: begin
               Rout    = NUM_REGS'(1) << rc;
               alu_op  = ALU_OP_W'(dec.op);
               Zin     = 1'b1;
               state_d = T5;
            end
            T5: begin
               Zlowout = 1'b1;
               if (dec.wide) begin
                  LOin    = 1'b1;
                  state_d = T6;
               end else begin
                  Rin     = NUM_REGS'(1) << ra;
                  retire  = 1'b1;
                  state_d = T0;
               end
            end
            T6: begin
               Zhighout = 1'b1;
               HIin     = 1'b1;
               retire   = 1'b1;
               state_d  = T0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: random instruction stream with
// wait states, stalls and a mid-instruction clear.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   localparam int CW = 4;

   localparam logic [13:0] M_PCOUT  = 14'h2000;
   localparam logic [13:0] M_ZLO    = 14'h1000;
   localparam logic [13:0] M_ZHI    = 14'h0800;
   localparam logic [13:0] M_MDROUT = 14'h0400;
   localparam logic [13:0] M_MARIN  = 14'h0200;
   localparam logic [13:0] M_PCIN   = 14'h0100;
   localparam logic [13:0] M_MDRIN  = 14'h0080;
   localparam logic [13:0] M_IRIN   = 14'h0040;
   localparam logic [13:0] M_YIN    = 14'h0020;
   localparam logic [13:0] M_ZIN    = 14'h0010;
   localparam logic [13:0] M_HIIN   = 14'h0008;
   localparam logic [13:0] M_LOIN   = 14'h0004;
   localparam logic [13:0] M_INCPC  = 14'h0002;
   localparam logic [13:0] M_READ   = 14'h0001;

   typedef struct packed {
      logic [3:0]    st;
      logic [13:0]   strb;
      logic [15:0]   rout;
      logic [15:0]   rin;
      logic [3:0]    op;
      logic          ill;
      logic [CW-1:0] cnt;
   } exp_t;

   logic          Clock = 1'b0;
   logic          clear, run, mem_ready;
   logic [31:0]   ir;
   logic          PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin;
   logic          IRin, Yin, Zin, HIin, LOin, IncPC, Read;
   logic [15:0]   Rout, Rin;
   logic [3:0]    alu_op;
   logic          illegal;
   logic [CW-1:0] instr_count;
   logic [3:0]    state;

   exp_t          sb[$];
   logic [CW-1:0] mdl_cnt;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc_no = 0;
   logic [3:0]    nop_op;

   alu_sequencer #(
      .DATA_W(32), .NUM_REGS(16), .OPC_W(5), .ALU_OP_W(4), .CNT_W(CW)
   ) dut (
      .Clock(Clock), .clear(clear), .run(run), .mem_ready(mem_ready),
      .ir(ir), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
      .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin),
      .alu_op(alu_op), .illegal(illegal), .instr_count(instr_count),
      .state(state)
   );

   always #5 Clock = ~Clock;

   // Reference decode of the instruction set.
   task automatic ref_dec(input logic [4:0] opc, output logic [3:0] op,
                          output bit legal, output bit wide,
                          output bit nop);
      op = ALU_NOP; legal = 1; wide = 0; nop = 0;
      case (opc)
         5'b00011: op = ALU_ADD;
         5'b00100: op = ALU_SUB;
         5'b00101: op = ALU_AND;
         5'b00110: op = ALU_OR;
         5'b00111: op = ALU_SHR;
         5'b01001: op = ALU_SHL;
         5'b01010: op = ALU_ROR;
         5'b01011: op = ALU_ROL;
         5'b01111: begin op = ALU_MUL; wide = 1; end
         5'b10000: begin op = ALU_DIV; wide = 1; end
         5'b11010: nop = 1;
         default:  legal = 0;
      endcase
   endtask

   task automatic put(input logic [3:0] st, input logic [13:0] strb,
                      input logic [15:0] ro, input logic [15:0] ri,
                      input logic [3:0] op, input logic ill);
      exp_t e;
      e.st = st; e.strb = strb; e.rout = ro; e.rin = ri;
      e.op = op; e.ill = ill; e.cnt = mdl_cnt;
      sb.push_back(e);
   endtask

   task automatic stall(input logic [3:0] st, input int n);
      for (int i = 0; i < n; i++) begin
         run = 1'b0;
         mem_ready = 1'($urandom);
         put(st, '0, '0, '0, nop_op, 1'b0);
         @(posedge Clock); #1;
      end
   endtask

   task automatic cyc(input logic [3:0] st, input logic [13:0] strb,
                      input logic [15:0] ro, input logic [15:0] ri,
                      input logic [3:0] op, input logic ill,
                      input logic mr, input bit ret);
      if ($urandom_range(0, 7) == 0) stall(st, $urandom_range(1, 3));
      run = 1'b1;
      mem_ready = mr;
      put(st, strb, ro, ri, op, ill);
      @(posedge Clock); #1;
      if (ret) mdl_cnt = mdl_cnt + 1'b1;
   endtask

   task automatic do_instr(input logic [4:0] opc, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [3:0] rc,
                           input logic [14:0] lo, input int waits,
                           input bit stall_t4, input bit clr_t4);
      logic [3:0] op;
      bit legal, wide, nop;
      ref_dec(opc, op, legal, wide, nop);
      cyc(T0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, '0, '0, nop_op, 0,
          1'($urandom), 0);
      for (int w = 0; w < waits; w++)
         cyc(T1, M_ZLO | M_READ | M_MDRIN, '0, '0, nop_op, 0, 1'b0, 0);
      cyc(T1, M_ZLO | M_READ | M_MDRIN | M_PCIN, '0, '0, nop_op, 0,
          1'b1, 0);
      ir = {opc, ra, rb, rc, lo};
      cyc(T2, M_MDROUT | M_IRIN, '0, '0, nop_op, 0, 1'($urandom), 0);
      if (!legal) begin
         cyc(T3, '0, '0, '0, nop_op, 1'b1, 1'($urandom), 0);
         return;
      end
      if (nop) begin
         cyc(T3, '0, '0, '0, nop_op, 1'b0, 1'($urandom), 1);
         return;
      end
      cyc(T3, M_YIN, 16'(1) << rb, '0, nop_op, 0, 1'($urandom), 0);
      if (clr_t4) begin
         clear = 1'b0;
         run = 1'($urandom);
         mdl_cnt = '0;
         put(IDLE, '0, '0, '0, nop_op, 1'b0);
         @(posedge Clock); #1;
         clear = 1'b1;
         cyc(IDLE, '0, '0, '0, nop_op, 0, 1'($urandom), 0);
         return;
      end
      if (stall_t4) stall(T4, 5);
      cyc(T4, M_ZIN, 16'(1) << rc, '0, op, 0, 1'($urandom), 0);
      if (wide) begin
         cyc(T5, M_ZLO | M_LOIN, '0, '0, nop_op, 0, 1'($urandom), 0);
         cyc(T6, M_ZHI | M_HIIN, '0, '0, nop_op, 0, 1'($urandom), 1);
      end else begin
         cyc(T5, M_ZLO, '0, 16'(1) << ra, nop_op, 0, 1'($urandom), 1);
      end
   endtask

   always @(negedge Clock) begin
      exp_t a, e;
      cyc_no++;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         a.st = state;
         a.strb = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin,
                   IRin, Yin, Zin, HIin, LOin, IncPC, Read};
         a.rout = Rout; a.rin = Rin; a.op = alu_op;
         a.ill = illegal; a.cnt = instr_count;
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL cycle%0d got st=%0d strb=%h rout=%h rin=%h op=%0d ill=%b cnt=%0d want st=%0d strb=%h rout=%h rin=%h op=%0d ill=%b cnt=%0d",
                     cyc_no, a.st, a.strb, a.rout, a.rin, a.op, a.ill,
                     a.cnt, e.st, e.strb, e.rout, e.rin, e.op, e.ill,
                     e.cnt);
         end
      end
   end

   localparam logic [4:0] LEGAL_OPS [11] = '{
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01001,
      5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b11010
   };

   initial begin
      logic [4:0] opc;
      nop_op = ALU_NOP;
      mdl_cnt = '0;
      clear = 1'b0;
      run = 1'b0;
      mem_ready = 1'b0;
      ir = '0;
      @(posedge Clock); #1;
      put(IDLE, '0, '0, '0, nop_op, 1'b0);
      @(posedge Clock); #1;
      clear = 1'b1;
      stall(IDLE, 2);
      cyc(IDLE, '0, '0, '0, nop_op, 0, 1'b1, 0);
      // Directed: AND, AND with waits, MUL, illegal, T4 stall, clear.
      do_instr(5'b00101, 4'd1, 4'd2, 4'd3, 15'h0, 0, 0, 0);
      do_instr(5'b00101, 4'd1, 4'd2, 4'd3, 15'h0, 3, 0, 0);
      do_instr(5'b01111, 4'd1, 4'd2, 4'd3, 15'h0, 0, 0, 0);
      do_instr(5'b11111, 4'd4, 4'd5, 4'd6, 15'h0, 0, 0, 0);
      do_instr(5'b00011, 4'd7, 4'd8, 4'd9, 15'h1234, 1, 1, 0);
      do_instr(5'b10000, 4'd15, 4'd0, 4'd14, 15'h7fff, 0, 0, 0);
      do_instr(5'b00100, 4'd2, 4'd3, 4'd4, 15'h0, 0, 0, 1);
      for (int i = 0; i < 17; i++)
         do_instr(5'b11010, 4'd0, 4'd0, 4'd0, 15'h0, 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 8)
            opc = LEGAL_OPS[$urandom_range(0, 10)];
         else
            opc = 5'($urandom);
         do_instr(opc, 4'($urandom), 4'($urandom), 4'($urandom),
                  15'($urandom),
                  ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4),
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 39) == 0);
      end
      run = 1'b0;
      @(posedge Clock); #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
